hci_core_cmd_issuer: RTL and testbench

- Initiator-side companion to the streamer command queue.
- Holds a small table of address-generator commands programmed by the controller.
- Replays the table REPEAT times toward a command queue or streamer using the hci_streamer_ctrl_t / hci_streamer_flags_t handshake.
- Tracks downstream completions and signals run end. Sits between the HWPE register file/controller and the per-streamer command queue.

---
 rtl/hci_core_cmd_issuer_pkg.sv | 35 +++
 rtl/hci_core_outstanding_cnt.sv | 42 ++++
 rtl/hci_core_cmd_issuer.sv | 179 +++++++++++++++++
 tb/tb_hci_core_cmd_issuer.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hci_core_cmd_issuer_pkg.sv
// Shared types for the command issuer: streamer handshake structs, the
// address-generator command word and the issuer FSM state encoding.
package hci_core_cmd_issuer_pkg;

  localparam int unsigned HCI_ADDRGEN_W = 226;

  typedef struct packed {
    logic [31:0] base_addr;
    logic [31:0] tot_len;
    logic [31:0] d0_len;
    logic [31:0] d0_stride;
    logic [31:0] d1_len;
    logic [31:0] d1_stride;
    logic [31:0] d2_stride;
    logic [1:0]  dim_enable_1h;
  } ctrl_addressgen_v3_t;

  typedef struct packed {
    logic                req_start;
    ctrl_addressgen_v3_t addressgen_ctrl;
  } hci_streamer_ctrl_t;

  typedef struct packed {
    logic ready_start;
    logic done;
  } hci_streamer_flags_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } hci_cmd_issuer_state_e;

endpackage

// File: rtl/hci_core_outstanding_cnt.sv
// Saturating up/down counter of commands accepted downstream but not yet
// completed; flags an underflow when a completion arrives with nothing pending.
module hci_core_outstanding_cnt
  import hci_core_cmd_issuer_pkg::*;
#(
  parameter  int unsigned MAX_CNT = 2,
  localparam int unsigned CW      = $clog2(MAX_CNT + 1)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          clear_i,
  input  logic          inc_i,
  input  logic          dec_i,
  output logic [CW-1:0] cnt_o,
  output logic          full_o,
  output logic          empty_o,
  output logic          underflow_o
);

  logic [CW-1:0] cnt_q;

  always_comb begin
    full_o      = (cnt_q == CW'(MAX_CNT));
    empty_o     = (cnt_q == '0);
    underflow_o = dec_i & ~inc_i & empty_o;
    cnt_o       = cnt_q;
  end

  // Simultaneous inc and dec cancel; ends are clamped so the count never wraps.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (clear_i) begin
      cnt_q <= '0;
    end else if (inc_i & ~dec_i & ~full_o) begin
      cnt_q <= cnt_q + CW'(1);
    end else if (dec_i & ~inc_i & ~empty_o) begin
      cnt_q <= cnt_q - CW'(1);
    end
  end

endmodule

// File: rtl/hci_core_cmd_issuer.sv
// Replays a small programmed table of address-generator commands toward a
// streamer command queue, REPEAT times, and reports run completion.
//
// state | meaning
// IDLE  | table programmable, waiting for start_i
// ISSUE | presenting table[idx], req_start while below outstanding cap
// DRAIN | all commands issued, waiting for outstanding to reach 0
// DONE  | one-cycle done_o pulse, back to IDLE
module hci_core_cmd_issuer
  import hci_core_cmd_issuer_pkg::*;
#(
  parameter  int unsigned NB_CMD          = 4,
  parameter  int unsigned MAX_OUTSTANDING = 2,
  parameter  int unsigned REPEAT_W        = 16,
  localparam int unsigned IW              = (NB_CMD > 1) ? $clog2(NB_CMD) : 1,
  localparam int unsigned OW              = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                clear_i,
  input  logic                prog_valid_i,
  output logic                prog_ready_o,
  input  ctrl_addressgen_v3_t prog_ctrl_i,
  input  logic                start_i,
  input  logic [REPEAT_W-1:0] repeat_i,
  output hci_streamer_ctrl_t  ctrl_o,
  input  hci_streamer_flags_t flags_i,
  input  logic                stream_done_i,
  output logic                busy_o,
  output logic                done_o,
  output logic [IW:0]         cmd_cnt_o,
  output logic                err_o
);

  hci_cmd_issuer_state_e state_q, state_d;

  ctrl_addressgen_v3_t table_q [NB_CMD];
  ctrl_addressgen_v3_t cmd_q;
  ctrl_addressgen_v3_t first_cmd;
  logic [IW:0]         cmd_cnt_q;
  logic [IW:0]         eff_cnt;
  logic [IW-1:0]       idx_q;
  logic [IW-1:0]       idx_nxt;
  logic [REPEAT_W-1:0] iter_q;
  logic                err_q;

  logic          prog_fire;
  logic          start_go;
  logic          req_start;
  logic          accept;
  logic          last_idx;
  logic          last_pass;
  logic          out_full;
  logic          out_empty;
  logic          out_underflow;
  logic [OW-1:0] outstanding;
  logic          unused_flags_done;

  assign unused_flags_done = flags_i.done;

  hci_core_outstanding_cnt #(
    .MAX_CNT (MAX_OUTSTANDING)
  ) u_outstanding_cnt (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .clear_i     (clear_i),
    .inc_i       (accept),
    .dec_i       (stream_done_i),
    .cnt_o       (outstanding),
    .full_o      (out_full),
    .empty_o     (out_empty),
    .underflow_o (out_underflow)
  );

  always_comb begin
    prog_ready_o = (state_q == IDLE) && (cmd_cnt_q < (IW + 1)'(NB_CMD));
    prog_fire    = prog_valid_i & prog_ready_o;
    // A write landing in the start cycle counts toward the run.
    eff_cnt      = cmd_cnt_q + {{IW{1'b0}}, prog_fire};
    start_go     = (state_q == IDLE) & start_i;
    req_start    = (state_q == ISSUE) & ~out_full;
    accept       = req_start & flags_i.ready_start;
    last_idx     = ({1'b0, idx_q} == (cmd_cnt_q - (IW + 1)'(1)));
    last_pass    = (iter_q == REPEAT_W'(1));
    idx_nxt      = last_idx ? '0 : idx_q + IW'(1);
    first_cmd    = (cmd_cnt_q == '0) ? prog_ctrl_i : table_q[0];
  end

  always_comb begin
    state_d = state_q;
    done_o  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = (eff_cnt == '0) ? DONE : ISSUE;
        end
      end
      ISSUE: begin
        if (accept && last_idx && last_pass) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (out_empty) begin
          state_d = DONE;
        end
      end
      DONE: begin
        done_o  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else if (clear_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NB_CMD; i++) table_q[i] <= '0;
      cmd_cnt_q <= '0;
    end else if (clear_i) begin
      for (int i = 0; i < NB_CMD; i++) table_q[i] <= '0;
      cmd_cnt_q <= '0;
    end else if (prog_fire) begin
      table_q[cmd_cnt_q[IW-1:0]] <= prog_ctrl_i;
      cmd_cnt_q                  <= cmd_cnt_q + (IW + 1)'(1);
    end
  end

  // cmd_q is preloaded with the next entry so the presented command is a
  // plain register and stays stable while the queue back-pressures.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      idx_q  <= '0;
      iter_q <= '0;
      cmd_q  <= '0;
    end else if (clear_i) begin
      idx_q  <= '0;
      iter_q <= '0;
      cmd_q  <= '0;
    end else if (start_go && (eff_cnt != '0)) begin
      idx_q  <= '0;
      iter_q <= (repeat_i == '0) ? REPEAT_W'(1) : repeat_i;
      cmd_q  <= first_cmd;
    end else if (accept) begin
      idx_q <= idx_nxt;
      if (last_idx) begin
        iter_q <= iter_q - REPEAT_W'(1);
      end
      cmd_q <= (last_idx && last_pass) ? '0 : table_q[idx_nxt];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_q <= 1'b0;
    end else if (clear_i) begin
      err_q <= 1'b0;
    end else if (out_underflow) begin
      err_q <= 1'b1;
    end
  end

  assign ctrl_o.req_start       = req_start;
  assign ctrl_o.addressgen_ctrl = cmd_q;
  assign busy_o                 = (state_q != IDLE);
  assign cmd_cnt_o              = cmd_cnt_q;
  assign err_o                  = err_q;

endmodule

// File: tb/tb_hci_core_cmd_issuer.sv
// Directed bench for hci_core_cmd_issuer: replay order, back-pressure,
// table limits, outstanding accounting, async reset and repeat=0.
module tb_hci_core_cmd_issuer;
  import hci_core_cmd_issuer_pkg::*;

  logic                clk_i = 1'b0;
  logic                rst_i;
  logic                clear_i;
  logic                prog_valid_i;
  logic                prog_ready_o;
  ctrl_addressgen_v3_t prog_ctrl_i;
  logic                start_i;
  logic [15:0]         repeat_i;
  hci_streamer_ctrl_t  ctrl_o;
  hci_streamer_flags_t flags_i;
  logic                stream_done_i;
  logic                busy_o;
  logic                done_o;
  logic [2:0]          cmd_cnt_o;
  logic                err_o;

  logic auto_sd = 1'b0;
  logic man_sd;
  logic auto_en;
  assign stream_done_i = auto_sd | man_sd;

  always #5 clk_i = ~clk_i;

  hci_core_cmd_issuer #(
    .NB_CMD          (4),
    .MAX_OUTSTANDING (2),
    .REPEAT_W        (16)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .clear_i       (clear_i),
    .prog_valid_i  (prog_valid_i),
    .prog_ready_o  (prog_ready_o),
    .prog_ctrl_i   (prog_ctrl_i),
    .start_i       (start_i),
    .repeat_i      (repeat_i),
    .ctrl_o        (ctrl_o),
    .flags_i       (flags_i),
    .stream_done_i (stream_done_i),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .cmd_cnt_o     (cmd_cnt_o),
    .err_o         (err_o)
  );

  // Monitor: counts events mid-cycle and models a streamer that completes
  // each accepted command two cycles after acceptance.
  int          acc_cnt = 0;
  int          done_cnt = 0;
  int          req_cnt = 0;
  int          viol_cnt = 0;
  int          sd_cnt = 0;
  int          sd_at_done = 0;
  logic [31:0] acc_q[$];
  logic        sd_d0 = 1'b0;
  logic        sd_d1 = 1'b0;

  always @(negedge clk_i) begin
    if (ctrl_o.req_start) req_cnt++;
    if (ctrl_o.req_start && dut.outstanding == 2'd2) viol_cnt++;
    if (ctrl_o.req_start && flags_i.ready_start) begin
      acc_cnt++;
      acc_q.push_back(ctrl_o.addressgen_ctrl.base_addr);
    end
    if (done_o) begin
      done_cnt++;
      sd_at_done = sd_cnt;
    end
    if (stream_done_i) sd_cnt++;
    if (rst_i || clear_i) begin
      sd_d0   = 1'b0;
      sd_d1   = 1'b0;
      auto_sd = 1'b0;
    end else begin
      auto_sd = auto_en & sd_d1;
      sd_d1   = sd_d0;
      sd_d0   = ctrl_o.req_start & flags_i.ready_start;
    end
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic prog(input logic [31:0] addr);
    prog_valid_i          = 1'b1;
    prog_ctrl_i           = '0;
    prog_ctrl_i.base_addr = addr;
    prog_ctrl_i.tot_len   = addr >> 4;
    tick();
    prog_valid_i = 1'b0;
  endtask

  task automatic start_run(input logic [15:0] rep);
    repeat_i = rep;
    start_i  = 1'b1;
    tick();
    start_i  = 1'b0;
  endtask

  task automatic do_clear();
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int d0;
    int k;
    d0 = done_cnt;
    k  = 0;
    while (done_cnt == d0 && k < budget) begin
      tick();
      k++;
    end
    chk(tag, 64'(done_cnt > d0), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0;
    int d0;
    int v0;
    int s0;
    int r0;
    logic [31:0] exp_addr;

    rst_i        = 1'b1;
    clear_i      = 1'b0;
    prog_valid_i = 1'b0;
    prog_ctrl_i  = '0;
    start_i      = 1'b0;
    repeat_i     = '0;
    flags_i      = '0;
    man_sd       = 1'b0;
    auto_en      = 1'b0;
    repeat (3) tick();

    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_done", 64'(done_o), 64'd0);
    chk("rst_err", 64'(err_o), 64'd0);
    chk("rst_req", 64'(ctrl_o.req_start), 64'd0);
    chk("rst_cmd_cnt", 64'(cmd_cnt_o), 64'd0);
    chk("rst_ctrl_data", 64'(ctrl_o.addressgen_ctrl.base_addr), 64'd0);
    rst_i = 1'b0;
    tick();
    chk("rst_prog_ready", 64'(prog_ready_o), 64'd1);

    // Three commands replayed twice, always ready, completions two cycles late.
    prog(32'h100);
    prog(32'h200);
    prog(32'h300);
    chk("t1_cmd_cnt", 64'(cmd_cnt_o), 64'd3);
    flags_i.ready_start = 1'b1;
    auto_en = 1'b1;
    a0 = acc_cnt; d0 = done_cnt; v0 = viol_cnt; s0 = sd_cnt;
    start_run(16'd2);
    chk("t1_first_req", 64'(ctrl_o.req_start), 64'd1);
    chk("t1_busy", 64'(busy_o), 64'd1);
    wait_done("t1_done_seen", 80);
    repeat (3) tick();
    chk("t1_accepts", 64'(acc_cnt - a0), 64'd6);
    for (int i = 0; i < 6; i++) begin
      exp_addr = 32'h100 * 32'((i % 3) + 1);
      chk($sformatf("t1_order%0d", i), 64'(acc_q[a0 + i]), 64'(exp_addr));
    end
    chk("t1_cap_viol", 64'(viol_cnt - v0), 64'd0);
    chk("t1_done_once", 64'(done_cnt - d0), 64'd1);
    chk("t1_sd_before_done", 64'(sd_at_done - s0), 64'd6);
    chk("t1_idle", 64'(busy_o), 64'd0);

    // Back-pressure: data held while ready_start is low.
    flags_i.ready_start = 1'b0;
    a0 = acc_cnt;
    start_run(16'd1);
    for (int i = 0; i < 5; i++) begin
      chk("t2_req_held", 64'(ctrl_o.req_start), 64'd1);
      chk("t2_data_stable", 64'(ctrl_o.addressgen_ctrl.base_addr), 64'h100);
      tick();
    end
    chk("t2_no_accept", 64'(acc_cnt - a0), 64'd0);
    flags_i.ready_start = 1'b1;
    tick();
    chk("t2_accept_first", 64'(acc_cnt - a0), 64'd1);
    chk("t2_accept_addr", 64'(acc_q[a0]), 64'h100);
    chk("t2_next_data", 64'(ctrl_o.addressgen_ctrl.base_addr), 64'h200);
    wait_done("t2_done_seen", 40);
    chk("t2_accepts", 64'(acc_cnt - a0), 64'd3);

    // Table fill limit, then an empty-table run.
    auto_en = 1'b0;
    flags_i.ready_start = 1'b0;
    repeat (4) tick();
    do_clear();
    chk("t3_clear_cnt", 64'(cmd_cnt_o), 64'd0);
    for (int i = 0; i < 4; i++) begin
      chk("t3_ready_fill", 64'(prog_ready_o), 64'd1);
      prog(32'h1000 + 32'(i));
    end
    chk("t3_ready_full", 64'(prog_ready_o), 64'd0);
    chk("t3_cnt_full", 64'(cmd_cnt_o), 64'd4);
    prog(32'hdead);
    chk("t3_cnt_no_ovf", 64'(cmd_cnt_o), 64'd4);
    do_clear();
    r0 = req_cnt; d0 = done_cnt;
    start_run(16'd3);
    repeat (3) tick();
    chk("t3_empty_done", 64'(done_cnt - d0), 64'd1);
    chk("t3_empty_no_req", 64'(req_cnt - r0), 64'd0);
    chk("t3_empty_idle", 64'(busy_o), 64'd0);

    // Outstanding accounting and underflow error.
    do_clear();
    prog(32'h500);
    a0 = acc_cnt;
    start_run(16'd3);
    flags_i.ready_start = 1'b1;
    tick();
    chk("t4_out_1", 64'(dut.outstanding), 64'd1);
    man_sd = 1'b1;
    tick();
    man_sd = 1'b0;
    chk("t4_out_net0", 64'(dut.outstanding), 64'd1);
    chk("t4_err_clean", 64'(err_o), 64'd0);
    tick();
    flags_i.ready_start = 1'b0;
    chk("t4_out_2", 64'(dut.outstanding), 64'd2);
    chk("t4_req_capped", 64'(ctrl_o.req_start), 64'd0);
    chk("t4_busy_drain", 64'(busy_o), 64'd1);
    man_sd = 1'b1;
    tick();
    tick();
    man_sd = 1'b0;
    chk("t4_out_0", 64'(dut.outstanding), 64'd0);
    wait_done("t4_done_seen", 5);
    chk("t4_accepts", 64'(acc_cnt - a0), 64'd3);
    man_sd = 1'b1;
    tick();
    man_sd = 1'b0;
    chk("t4_err_set", 64'(err_o), 64'd1);
    chk("t4_out_hold0", 64'(dut.outstanding), 64'd0);
    repeat (3) tick();
    chk("t4_err_sticky", 64'(err_o), 64'd1);
    do_clear();
    chk("t4_err_cleared", 64'(err_o), 64'd0);

    // Asynchronous reset in the middle of ISSUE.
    prog(32'h600);
    prog(32'h700);
    start_run(16'd1);
    chk("t5_req_before", 64'(ctrl_o.req_start), 64'd1);
    #2;
    rst_i = 1'b1;
    #1;
    chk("t5_req_async_drop", 64'(ctrl_o.req_start), 64'd0);
    tick();
    rst_i = 1'b0;
    tick();
    chk("t5_busy", 64'(busy_o), 64'd0);
    chk("t5_cmd_cnt", 64'(cmd_cnt_o), 64'd0);
    chk("t5_prog_ready", 64'(prog_ready_o), 64'd1);

    // repeat_i = 0 runs once; second entry written in the start cycle.
    prog(32'h800);
    flags_i.ready_start = 1'b1;
    auto_en = 1'b1;
    a0 = acc_cnt; d0 = done_cnt;
    prog_valid_i          = 1'b1;
    prog_ctrl_i           = '0;
    prog_ctrl_i.base_addr = 32'h900;
    repeat_i              = 16'd0;
    start_i               = 1'b1;
    tick();
    prog_valid_i = 1'b0;
    start_i      = 1'b0;
    wait_done("t6_done_seen", 40);
    repeat (3) tick();
    chk("t6_accepts", 64'(acc_cnt - a0), 64'd2);
    chk("t6_order0", 64'(acc_q[a0]), 64'h800);
    chk("t6_order1", 64'(acc_q[a0 + 1]), 64'h900);
    chk("t6_cmd_cnt", 64'(cmd_cnt_o), 64'd2);
    chk("t6_done_once", 64'(done_cnt - d0), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
